imem_boot_ctrl: RTL
===================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 32: instruction word and address width.
REQ-002 Parameter RAM_DEPTH, default 2048: instruction memory depth in words.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF: end-of-program marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout, used only under LOADER_TIMEOUT_EN.
REQ-005 clka  in  1: single clock; all state changes on the rising edge.
REQ-006 rsta_n  in  1: reset, asynchronous, active-low.
REQ-007 rx_data  in  8: received program byte.
REQ-008 rx_valid  in  1: one-cycle strobe qualifying rx_data.
REQ-009 start  in  1: one-cycle request to (re)load a program.
REQ-010 cpu_pc  in  RAM_WIDTH: CPU fetch byte address.
REQ-011 mem_addr  out  RAM_WIDTH: byte address to the instruction memory; the memory uses it as a word index after a shift right by 2.
REQ-012 mem_din  out  RAM_WIDTH: write data to the instruction memory.
REQ-013 mem_we  out  1: write enable to the instruction memory.
REQ-014 cpu_enable  out  1: CPU may fetch and execute.
REQ-015 load_done  out  1: program loaded and HALT_WORD written.
REQ-016 load_err  out  1: overflow, or timeout when LOADER_TIMEOUT_EN is defined.
REQ-017 word_count  out  clog2(RAM_DEPTH)+1: words written in the current load, including HALT_WORD.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, WRITE, RUN and ERROR.
REQ-019 IDLE: start moves the FSM to LOAD; write pointer, word_count and byte counter clear on the same edge.
REQ-020 LOAD: each rx_valid shifts rx_data into a 32-bit assembler, big-endian (the first byte becomes bits 31:24); on the 4th byte the FSM moves to WRITE.
REQ-021 WRITE lasts one cycle:
- mem_we=1, mem_addr=write pointer, mem_din=assembled word.
- word_count increments.
REQ-022 Exit from WRITE:
- word == HALT_WORD: go to RUN.
- else if the write pointer equals (RAM_DEPTH-1)*4: go to ERROR.
- else: write pointer += 4 and return to LOAD.
REQ-023 An rx_valid during WRITE SHALL be accepted as byte 0 of the next word and SHALL NOT be lost.
REQ-024 rx_valid in IDLE, RUN or ERROR SHALL be ignored.
REQ-025 start during LOAD or WRITE SHALL be ignored.
REQ-026 RUN: cpu_enable=1, load_done=1, mem_we=0, mem_addr=cpu_pc combinationally.
REQ-027 All states other than RUN: cpu_enable=0 and mem_addr=write pointer.
REQ-028 start in RUN or ERROR:
- goes to LOAD as in REQ-019.
- cpu_enable, load_done and load_err drop on that edge.
REQ-029 ERROR: load_err=1, cpu_enable=0, mem_we=0; holds until start or reset.
REQ-030 mem_we, mem_addr and mem_din SHALL be registered or FSM-decoded and stable for the full cycle, because the memory samples on the falling edge.

Reset
REQ-031 While rsta_n=0, the block SHALL hold:
- FSM state IDLE.
- mem_addr, mem_din, mem_we, cpu_enable, load_done, load_err and word_count all 0.
- Byte counter, assembler and write pointer all 0.
REQ-032 Reset asserted mid-LOAD or mid-WRITE SHALL abort immediately; words already written stay in memory, and no partial word is written.

Configuration
REQ-033 With LOADER_TIMEOUT_EN defined:
- In LOAD with byte counter 1-3, TIMEOUT_CYCLES consecutive cycles without rx_valid go to ERROR.
- The partial word is discarded.
- The timeout counter clears on each rx_valid.
REQ-034 Without LOADER_TIMEOUT_EN: no timeout counter exists, LOAD waits indefinitely, and load_err indicates overflow only.

Verification
REQ-035 Bytes 20 08 00 05 FF FF FF FF after start:
- Two WRITE cycles: addr 0 data 0x20080005, then addr 4 data 0xFFFFFFFF.
- Then load_done=1, cpu_enable=1, word_count=2.
REQ-036 In RUN, cpu_pc=0x10 -> mem_addr=0x10, mem_we=0.
REQ-037 rx_valid in the WRITE cycle -> that byte appears as bits 31:24 of the next written word.
REQ-038 RAM_DEPTH=4, four non-HALT words -> the write at addr 0xC completes, then ERROR, load_err=1, cpu_enable=0.
REQ-039 rsta_n low after 2 bytes of word 1 -> all outputs 0 and IDLE; start then reloads from addr 0.
REQ-040 LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, one byte then 10 idle cycles -> ERROR, no write; without the macro, no ERROR.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot loader: assembles big-endian bytes into words, writes them to instruction memory
// until HALT_WORD, then hands the memory port to the CPU. Define LOADER_TIMEOUT_EN for an inter-byte timeout.
module imem_boot_ctrl #(
    parameter int unsigned RAM_WIDTH      = 32,
    parameter int unsigned RAM_DEPTH      = 2048,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                        clka,
    input  logic                        rsta_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        start,
    input  logic [RAM_WIDTH-1:0]        cpu_pc,
    output logic [RAM_WIDTH-1:0]        mem_addr,
    output logic [RAM_WIDTH-1:0]        mem_din,
    output logic                        mem_we,
    output logic                        cpu_enable,
    output logic                        load_done,
    output logic                        load_err,
    output logic [$clog2(RAM_DEPTH):0]  word_count
);

    localparam int unsigned WC_W = $clog2(RAM_DEPTH) + 1;
    localparam logic [RAM_WIDTH-1:0] LAST_ADDR = RAM_WIDTH'((RAM_DEPTH - 1) * 4);

    if (RAM_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("imem_boot_ctrl: RAM_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, ERROR} state_t;

    state_t               state, state_nxt;
    logic [1:0]           byte_cnt;
    logic [31:0]          asm_word;
    logic [RAM_WIDTH-1:0] wr_ptr;
    logic                 restart;
    logic                 accept;
    logic                 timeout;

    assign restart = start && (state == IDLE || state == RUN || state == ERROR);
    // A byte arriving in WRITE is the first byte of the next word.
    assign accept  = rx_valid && (state == LOAD || state == WRITE);

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_armed;

    assign to_armed = (state == LOAD) && (byte_cnt != 2'd0) && !rx_valid;
    assign timeout  = to_armed && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)
            to_cnt <= '0;
        else if (to_armed && !timeout)
            to_cnt <= to_cnt + TO_W'(1);
        else
            to_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERROR: if (start) state_nxt = LOAD;
            LOAD: begin
                if (rx_valid && byte_cnt == 2'd3)
                    state_nxt = WRITE;
                else if (timeout)
                    state_nxt = ERROR;
            end
            WRITE: begin
                if (asm_word == HALT_WORD)
                    state_nxt = RUN;
                else if (wr_ptr == LAST_ADDR)
                    state_nxt = ERROR;
                else
                    state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            byte_cnt   <= '0;
            asm_word   <= '0;
            wr_ptr     <= '0;
            word_count <= '0;
        end else if (restart) begin
            byte_cnt   <= '0;
            asm_word   <= '0;
            wr_ptr     <= '0;
            word_count <= '0;
        end else begin
            if (accept) begin
                asm_word <= {asm_word[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (timeout)
                byte_cnt <= '0;
            if (state == WRITE) begin
                word_count <= word_count + WC_W'(1);
                if (state_nxt == LOAD)
                    wr_ptr <= wr_ptr + RAM_WIDTH'(4);
            end
        end
    end

    // Memory-side outputs decode directly from registers, so they hold for the whole cycle.
    assign mem_we     = (state == WRITE);
    assign mem_addr   = (state == RUN) ? cpu_pc : wr_ptr;
    assign mem_din    = RAM_WIDTH'(asm_word);
    assign cpu_enable = (state == RUN);
    assign load_done  = (state == RUN);
    assign load_err   = (state == ERROR);

endmodule
